// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready flow control.
// Decode happens before the output register; a one-entry skid register absorbs a single downstream stall.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    entry_t             e;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    opc   = inst[6:0];
    f3    = inst[14:12];
    imm_i = inst[31:20];
    imm_s = {inst[31:25], inst[11:7]};
    imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    e.imm = '0;
    e.fmt = FMT_NONE;
    e.ill = 1'b0;
    e.tag = tag;
    case (opc)
      7'b0010011: begin
        // Shift-immediates carry funct7 in the upper bits; only the shamt field is the operand.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          e.fmt = FMT_SHAMT;
          e.imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
        end else begin
          e.fmt = FMT_I;
          e.imm = XLEN'(imm_i);
        end
      end
      7'b0000011, 7'b1100111: begin
        e.fmt = FMT_I;
        e.imm = XLEN'(imm_i);
      end
      7'b0100011: begin
        e.fmt = FMT_S;
        e.imm = XLEN'(imm_s);
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        e.imm = XLEN'(imm_b);
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = FMT_U;
        e.imm = XLEN'(imm_u);
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        e.imm = XLEN'(imm_j);
      end
      7'b0110011, 7'b0001111, 7'b1110011: begin
        e.fmt = FMT_NONE;
      end
      default: begin
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  entry_t main_q, main_d, skid_q, skid_d, in_ent;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   accept, pop;

  always_comb begin
    in_ent     = decode(in_inst, in_tag);
    accept     = in_valid && !skid_vld_q;
    pop        = main_vld_q && out_ready;
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop || !main_vld_q) begin
      // Main slot frees up: the older skid entry has precedence over new input.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  // Stage boundary: output and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready    = !skid_vld_q;
  assign out_valid   = main_vld_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.ill;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [4:0]  in_tag;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [4:0]  tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [4:0]  tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[9];
  logic [6:0]  ops[11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};
  logic [31:0] cur_e32;
  logic [63:0] cur_e64;
  logic [2:0]  cur_fmt;
  logic        cur_ill;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sext(input longint x, input int bits);
    if (x >= (longint'(1) << (bits - 1))) return x - (longint'(1) << bits);
    return x;
  endfunction

  // Reference: immediate value computed arithmetically from the field definitions.
  function automatic void ref_model(input logic [31:0] inst, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
    longint     v  = 0;
    logic [6:0] op = inst[6:0];
    int         f3 = int'(inst[14:12]);
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      7'h03, 7'h67: begin fmt = 3'd1; v = sext(longint'(inst[31:20]), 12); end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = 3'd6;
          v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
        end else begin
          fmt = 3'd1;
          v = sext(longint'(inst[31:20]), 12);
        end
      end
      7'h23: begin fmt = 3'd2; v = sext(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12); end
      7'h63: begin
        fmt = 3'd3;
        v = sext(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                 longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin fmt = 3'd4; v = sext(longint'(inst[31:12]) * 4096, 32); end
      7'h6F: begin
        fmt = 3'd5;
        v = sext(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                 longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      end
      7'h33, 7'h0F, 7'h73: v = 0;
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
    if (xlen == 32) imm[63:32] = 32'h0;
  endfunction

  // Stimulus side: record every accepted instruction with its expected result.
  always @(posedge clk) begin
    if (!rst && !flush && in_valid && in_ready32)
      q.push_back('{cur_e32, cur_e64, cur_fmt, cur_ill, in_tag});
  end

  // Model of downstream consumption, flush and reset.
  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else if (out_valid32 && out_ready) begin
      if (q.size() == 0) check("pop_underflow", 64'(1), 64'(0));
      else void'(q.pop_front());
    end
  end

  // Monitor: compare the presented outputs against the head of the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      check("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      check("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      check("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        if (out_valid32) begin
          check("imm32", 64'(imm32), 64'(q[0].e32));
          check("fmt32", 64'(fmt32), 64'(q[0].fmt));
          check("ill32", 64'(ill32), 64'(q[0].ill));
          check("tag32", 64'(tag32), 64'(q[0].tag));
        end
        if (out_valid64) begin
          check("imm64", imm64, q[0].e64);
          check("fmt64", 64'(fmt64), 64'(q[0].fmt));
          check("ill64", 64'(ill64), 64'(q[0].ill));
          check("tag64", 64'(tag64), 64'(q[0].tag));
        end
      end
    end
  end

  task automatic set_vec(input int i, input logic [4:0] tag);
    in_valid = 1'b1;
    in_inst  = vecs[i].inst;
    in_tag   = tag;
    cur_e32  = vecs[i].e32;
    cur_e64  = vecs[i].e64;
    cur_fmt  = vecs[i].fmt;
    cur_ill  = vecs[i].ill;
  endtask

  task automatic set_rand();
    logic [31:0] inst;
    logic [63:0] i32, i64;
    logic [2:0]  f;
    logic        il;
    int          k;
    inst = $urandom();
    k    = $urandom_range(0, 13);
    if (k < 11) inst[6:0] = ops[k];
    else if (k < 13) begin
      inst[6:0]   = 7'h13;
      inst[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
    end
    ref_model(inst, 32, i32, f, il);
    ref_model(inst, 64, i64, f, il);
    in_inst = inst;
    in_tag  = 5'($urandom());
    cur_e32 = i32[31:0];
    cur_e64 = i64;
    cur_fmt = f;
    cur_ill = il;
  endtask

  // Called at a negedge with in_valid set; returns at the following negedge.
  task automatic wait_accept(output int cycles);
    bit acc = 1'b0;
    cycles = 0;
    while (!acc && cycles < 50) begin
      @(posedge clk);
      cycles++;
      acc = in_ready32;
    end
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int i, input logic [4:0] tag, output int cycles);
    set_vec(i, tag);
    wait_accept(cycles);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_out_valid"}, 64'(out_valid32 | out_valid64), 64'(0));
    check({pfx, "_in_ready"}, 64'(in_ready32 & in_ready64), 64'(1));
    check({pfx, "_imm32"}, 64'(imm32), 64'(0));
    check({pfx, "_imm64"}, imm64, 64'(0));
    check({pfx, "_fmt"}, 64'({fmt32, fmt64}), 64'(0));
    check({pfx, "_ill"}, 64'({ill32, ill64}), 64'(0));
    check({pfx, "_tag"}, 64'({tag32, tag64}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{32'hFFC12083, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    vecs[1] = '{32'h00512423, 32'h00000008, 64'h0000000000000008, 3'd2, 1'b0};
    vecs[2] = '{32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0};
    vecs[3] = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[4] = '{32'h0010006F, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0};
    vecs[5] = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd6, 1'b0};
    vecs[6] = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[7] = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[8] = '{32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd6, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_tag = 5'h0;
    cur_e32 = '0; cur_e64 = '0; cur_fmt = '0; cur_ill = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    chk_en = 1'b1;

    // Back-to-back stream with downstream always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_vec(i, 5'(i + 1), cyc);
      check("stream_accept_cycles", 64'(cyc), 64'(1));
    end
    repeat (3) @(negedge clk);

    // Backpressure: two entries fill main and skid, third is held off.
    out_ready = 1'b0;
    send_vec(0, 5'd1, cyc);
    send_vec(1, 5'd2, cyc);
    set_vec(2, 5'd3);
    check("bp_in_ready", 64'(in_ready32), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_hold", 64'(in_ready32), 64'(0));
      check("bp_main_tag", 64'(tag32), 64'(1));
    end
    out_ready = 1'b1;
    wait_accept(cyc);
    repeat (4) @(negedge clk);

    // Flush with both entries full and a pending input.
    out_ready = 1'b0;
    send_vec(3, 5'd4, cyc);
    send_vec(4, 5'd5, cyc);
    set_vec(5, 5'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_out_valid", 64'(out_valid32), 64'(0));
    check("flush_full_in_ready", 64'(in_ready32), 64'(1));

    // Flush with one entry while an input would otherwise be accepted.
    send_vec(6, 5'd7, cyc);
    set_vec(7, 5'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_out_valid", 64'(out_valid32), 64'(0));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset asserted during a stall.
    out_ready = 1'b0;
    send_vec(8, 5'd9, cyc);
    send_vec(2, 5'd10, cyc);
    set_vec(3, 5'd11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_reset_state("stall_reset");

    // Randomized traffic.
    for (int c = 0; c < 10000; c++) begin
      set_rand();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end

    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("drain_empty", 64'(out_valid32), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
